// File: rtl/core_seq_ctrl_pkg.sv
// Shared types and instruction-word layout for the attention-core sequencer.
// Optional sum exchange/normalisation is enabled by defining SEQ_NORM_EN.
package core_seq_pkg;

    localparam int unsigned INST_W   = 30;

    localparam int unsigned KMEM_WR  = 0;
    localparam int unsigned KMEM_RD  = 1;
    localparam int unsigned QMEM_WR  = 2;
    localparam int unsigned QMEM_RD  = 3;
    localparam int unsigned PMEM_WR  = 4;
    localparam int unsigned PMEM_RD  = 5;
    localparam int unsigned EXECUTE  = 6;
    localparam int unsigned LOAD     = 7;
    localparam int unsigned OFIFO_RD = 8;
    localparam int unsigned DIV      = 9;
    localparam int unsigned ACC      = 10;
    localparam int unsigned ADDR_LSB = 11;
    localparam int unsigned ADDR_MSB = 16;

    localparam int unsigned CTL_W    = ADDR_LSB;
    localparam int unsigned ADDR_FW  = ADDR_MSB - ADDR_LSB + 1;

    typedef logic [CTL_W-1:0] ctl_t;

    localparam ctl_t C_KMEM_WR  = ctl_t'(1 << KMEM_WR);
    localparam ctl_t C_QMEM_WR  = ctl_t'(1 << QMEM_WR);
    localparam ctl_t C_KFETCH   = ctl_t'((1 << KMEM_RD) | (1 << LOAD));
    localparam ctl_t C_EXEC     = ctl_t'((1 << QMEM_RD) | (1 << EXECUTE) | (1 << PMEM_WR));
    localparam ctl_t C_PMEM_RD  = ctl_t'(1 << PMEM_RD);
    localparam ctl_t C_NORM     = ctl_t'((1 << DIV) | (1 << ACC) | (1 << PMEM_WR));
    localparam ctl_t C_OFIFO_RD = ctl_t'(1 << OFIFO_RD);

    typedef enum logic [3:0] {
        IDLE,
        KLOAD,
        QLOAD,
        KFETCH,
        EXEC,
        SUMX,
        NORM,
        DRAIN,
        DONE
    } seq_state_t;

    // Sub-steps of one sum-exchange row: push local sum, wait for peer, pop.
    typedef enum logic [1:0] {
        SX_WR,
        SX_WAIT,
        SX_POP
    } sumx_phase_t;

    function automatic logic [INST_W-1:0] inst_word(input ctl_t ctl,
                                                    input logic [ADDR_FW-1:0] a);
        logic [INST_W-1:0] w;
        w                     = '0;
        w[CTL_W-1:0]          = ctl;
        w[ADDR_MSB:ADDR_LSB]  = a;
        return w;
    endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Command/status bundle between a host and one core sequencer.
interface core_seq_ctrl_if
    import core_seq_pkg::*;
#(
    parameter int unsigned addr_bw = 6
);
    logic               start;
    logic [addr_bw-1:0] num_k;
    logic [addr_bw-1:0] num_q;
    logic               sum_ready;
    logic               ofifo_valid;
    logic [INST_W-1:0]  inst;
    logic               fifo_ext_rd;
    logic               wr_sum;
    logic               busy;
    logic               done;

    modport master (
        output start, num_k, num_q, sum_ready, ofifo_valid,
        input  inst, fifo_ext_rd, wr_sum, busy, done
    );

    modport slave (
        input  start, num_k, num_q, sum_ready, ofifo_valid,
        output inst, fifo_ext_rd, wr_sum, busy, done
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// Per-core instruction sequencer: one start pulse drives a full K/Q/exec/drain pass.
// Define SEQ_NORM_EN to add the per-row sum exchange and normalisation steps.
module core_seq_ctrl
    import core_seq_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned pr      = 8,
    parameter int unsigned addr_bw = 6
) (
    input  logic         clk,
    input  logic         reset,
    core_seq_ctrl_if.slave bus
);

    if (col == 0 || col > (1 << addr_bw)) begin : g_col_chk
        $error("col must be 1..2^addr_bw so the address counter can reach col-1");
    end
    if (pr == 0) begin : g_pr_chk
        $error("pr must be non-zero");
    end

    localparam logic [addr_bw-1:0] COL_LAST = addr_bw'(col - 1);

    seq_state_t          state, nxt_state;
    logic [addr_bw-1:0]  addr, nxt_addr;
    logic [addr_bw-1:0]  pops, nxt_pops;
    logic [addr_bw-1:0]  k_cnt, nxt_k_cnt;
    logic [addr_bw-1:0]  q_cnt, nxt_q_cnt;
    logic [addr_bw-1:0]  k_last, q_last;
    logic                bubble, nxt_bubble;
    logic                enter_drain;
    logic [INST_W-1:0]   inst_q, nxt_inst;
    logic                busy_q, done_q, nxt_done;

`ifdef SEQ_NORM_EN
    logic [addr_bw-1:0]  row, nxt_row;
    sumx_phase_t         sphase, nxt_sphase;
    logic                wr_q, nxt_wr, pop_q, nxt_pop;
`endif

    function automatic logic [ADDR_FW-1:0] fa(input logic [addr_bw-1:0] a);
        return ADDR_FW'(a);
    endfunction

    assign k_last = k_cnt - 1'b1;
    assign q_last = q_cnt - 1'b1;

    // Every output is registered, so this block computes the word for the
    // cycle in which the next state is current.
    always_comb begin
        nxt_state   = state;
        nxt_addr    = addr;
        nxt_pops    = pops;
        nxt_k_cnt   = k_cnt;
        nxt_q_cnt   = q_cnt;
        nxt_bubble  = bubble;
        nxt_inst    = '0;
        nxt_done    = 1'b0;
        enter_drain = 1'b0;
`ifdef SEQ_NORM_EN
        nxt_row     = row;
        nxt_sphase  = sphase;
        nxt_wr      = 1'b0;
        nxt_pop     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nxt_k_cnt = (bus.num_k == '0) ? addr_bw'(1) : bus.num_k;
                    nxt_q_cnt = (bus.num_q == '0) ? addr_bw'(1) : bus.num_q;
                    nxt_addr  = '0;
                    nxt_state = KLOAD;
                    nxt_inst  = inst_word(C_KMEM_WR, '0);
                end
            end
            KLOAD: begin
                if (addr == k_last) begin
                    nxt_state = QLOAD;
                    nxt_addr  = '0;
                    nxt_inst  = inst_word(C_QMEM_WR, '0);
                end else begin
                    nxt_addr  = addr + 1'b1;
                    nxt_inst  = inst_word(C_KMEM_WR, fa(addr + 1'b1));
                end
            end
            QLOAD: begin
                if (addr == q_last) begin
                    nxt_state = KFETCH;
                    nxt_addr  = '0;
                    nxt_inst  = inst_word(C_KFETCH, '0);
                end else begin
                    nxt_addr  = addr + 1'b1;
                    nxt_inst  = inst_word(C_QMEM_WR, fa(addr + 1'b1));
                end
            end
            KFETCH: begin
                if (bubble) begin
                    nxt_bubble = 1'b0;
                    nxt_state  = EXEC;
                    nxt_addr   = '0;
                    nxt_inst   = inst_word(C_EXEC, '0);
                end else if (addr == COL_LAST) begin
                    nxt_bubble = 1'b1;
                end else begin
                    nxt_addr   = addr + 1'b1;
                    nxt_inst   = inst_word(C_KFETCH, fa(addr + 1'b1));
                end
            end
            EXEC: begin
                if (addr == q_last) begin
`ifdef SEQ_NORM_EN
                    nxt_state  = SUMX;
                    nxt_row    = '0;
                    nxt_sphase = SX_WR;
                    nxt_wr     = 1'b1;
                    nxt_inst   = inst_word(C_PMEM_RD, '0);
`else
                    enter_drain = 1'b1;
`endif
                end else begin
                    nxt_addr  = addr + 1'b1;
                    nxt_inst  = inst_word(C_EXEC, fa(addr + 1'b1));
                end
            end
`ifdef SEQ_NORM_EN
            SUMX: begin
                case (sphase)
                    SX_WR, SX_WAIT: begin
                        if (bus.sum_ready) begin
                            nxt_sphase = SX_POP;
                            nxt_pop    = 1'b1;
                        end else begin
                            nxt_sphase = SX_WAIT;
                        end
                    end
                    SX_POP: begin
                        nxt_state = NORM;
                        nxt_inst  = inst_word(C_NORM, fa(row));
                    end
                    default: nxt_sphase = SX_WR;
                endcase
            end
            NORM: begin
                if (row == q_last) begin
                    enter_drain = 1'b1;
                end else begin
                    nxt_row    = row + 1'b1;
                    nxt_state  = SUMX;
                    nxt_sphase = SX_WR;
                    nxt_wr     = 1'b1;
                    nxt_inst   = inst_word(C_PMEM_RD, fa(row + 1'b1));
                end
            end
`endif
            DRAIN: begin
                if (pops == q_cnt) begin
                    nxt_state = DONE;
                end else if (bus.ofifo_valid) begin
                    nxt_pops  = pops + 1'b1;
                    nxt_inst  = inst_word(C_OFIFO_RD, '0);
                end
            end
            DONE: begin
                nxt_state = IDLE;
                nxt_done  = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase

        // The first pop may already issue on the entering edge.
        if (enter_drain) begin
            nxt_state = DRAIN;
            nxt_pops  = bus.ofifo_valid ? addr_bw'(1) : '0;
            nxt_inst  = bus.ofifo_valid ? inst_word(C_OFIFO_RD, '0) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr   <= '0;
            pops   <= '0;
            k_cnt  <= '0;
            q_cnt  <= '0;
            bubble <= 1'b0;
            inst_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            addr   <= nxt_addr;
            pops   <= nxt_pops;
            k_cnt  <= nxt_k_cnt;
            q_cnt  <= nxt_q_cnt;
            bubble <= nxt_bubble;
            inst_q <= nxt_inst;
            busy_q <= (nxt_state != IDLE);
            done_q <= nxt_done;
        end
    end

`ifdef SEQ_NORM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row    <= '0;
            sphase <= SX_WR;
            wr_q   <= 1'b0;
            pop_q  <= 1'b0;
        end else begin
            row    <= nxt_row;
            sphase <= nxt_sphase;
            wr_q   <= nxt_wr;
            pop_q  <= nxt_pop;
        end
    end

    assign bus.wr_sum      = wr_q;
    assign bus.fifo_ext_rd = pop_q;
`else
    assign bus.wr_sum      = 1'b0;
    assign bus.fifo_ext_rd = 1'b0;
`endif

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl (col=8, addr_bw=6); honours SEQ_NORM_EN.
module tb_core_seq_ctrl;

    localparam logic [10:0] KWR = 11'h001, KRD = 11'h002, QWR = 11'h004, QRD = 11'h008;
    localparam logic [10:0] PWR = 11'h010, PRD = 11'h020, EXE = 11'h040, LDB = 11'h080;
    localparam logic [10:0] ORD = 11'h100, DVB = 11'h200, ACB = 11'h400;
`ifdef SEQ_NORM_EN
    localparam int SX_OFF = 6;
`else
    localparam int SX_OFF = 0;
`endif

    typedef struct {
        logic [29:0] inst;
        logic        wr;
        logic        pop;
        logic        done;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   sr_delay = 0;
    ev_t  exp_q[$];

    core_seq_ctrl_if #(.addr_bw(6)) bus ();

    core_seq_ctrl #(.col(8), .pr(8), .addr_bw(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [29:0] iw(input logic [10:0] c, input int a);
        logic [5:0] a6;
        a6 = a[5:0];
        return {13'b0, a6, c};
    endfunction

    task automatic push_ev(input logic [29:0] i, input bit w, input bit p, input bit d, input int c);
        ev_t e;
        e.inst = i; e.wr = w; e.pop = p; e.done = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // mode 0: whole pass; 1: stop before drain; 2: stop after execute
    task automatic expect_pass(input int k, input int q, input int s, input int mode);
        int ke, qe, b;
        bit timed;
        ke = (k == 0) ? 1 : k;
        qe = (q == 0) ? 1 : q;
        b = s + 1;
        timed = 1'b1;
        for (int i = 0; i < ke; i++) push_ev(iw(KWR, i), 0, 0, 0, b + i);
        b += ke;
        for (int i = 0; i < qe; i++) push_ev(iw(QWR, i), 0, 0, 0, b + i);
        b += qe;
        for (int i = 0; i < 8; i++) push_ev(iw(KRD | LDB, i), 0, 0, 0, b + i);
        b += 9;
        for (int i = 0; i < qe; i++) push_ev(iw(QRD | EXE | PWR, i), 0, 0, 0, b + i);
        b += qe;
        if (mode == 2) return;
`ifdef SEQ_NORM_EN
        timed = 1'b0;
        for (int r = 0; r < qe; r++) begin
            push_ev(iw(PRD, r), 1, 0, 0, -1);
            push_ev(30'd0, 0, 1, 0, -1);
            push_ev(iw(DVB | ACB | PWR, r), 0, 0, 0, -1);
        end
`endif
        if (mode == 1) return;
        for (int i = 0; i < qe; i++) push_ev(iw(ORD, 0), 0, 0, 0, timed ? b + i : -1);
        b += qe;
        push_ev(30'd0, 0, 0, 1, timed ? b + 1 : -1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic do_start(input int k, input int q, input int mode, output int s);
        bus.num_k = 6'(k);
        bus.num_q = 6'(q);
        bus.start = 1'b1;
        s = cyc;
        expect_pass(k, q, s, mode);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && (bus.busy !== 1'b0 || exp_q.size() != 0); i++) tick();
        chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
        chk({name, "_pending"}, exp_q.size(), 32'd0);
        repeat (4) tick();
    endtask

    // Monitor: every visible DUT action must match the next expected event.
    always @(negedge clk) begin
        if (reset === 1'b0 &&
            (bus.inst != 30'd0 || bus.wr_sum || bus.fifo_ext_rd || bus.done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got inst=%h wr=%b pop=%b done=%b at cycle %0d, expected no output",
                         bus.inst, bus.wr_sum, bus.fifo_ext_rd, bus.done, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (bus.inst !== e.inst || bus.wr_sum !== e.wr || bus.fifo_ext_rd !== e.pop ||
                    bus.done !== e.done || (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL event: got inst=%h wr=%b pop=%b done=%b cyc=%0d, expected inst=%h wr=%b pop=%b done=%b cyc=%0d",
                             bus.inst, bus.wr_sum, bus.fifo_ext_rd, bus.done, cyc,
                             e.inst, e.wr, e.pop, e.done, e.cyc);
                end
            end
            if (bus.fifo_ext_rd) begin
                checks++;
                if (bus.sum_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL pop_without_ready: got sum_ready=%b, expected 1", bus.sum_ready);
                end
            end
        end
    end

`ifdef SEQ_NORM_EN
    // Peer model: answer each wr_sum after sr_delay cycles, retract once popped.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset === 1'b0 && bus.wr_sum === 1'b1) begin
                repeat (sr_delay) @(negedge clk);
                if (sr_delay != 0) #1;
                sr_delay = 0;
                bus.sum_ready = 1'b1;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    #1;
                    if (bus.fifo_ext_rd === 1'b1) break;
                end
                bus.sum_ready = 1'b0;
            end
        end
    end
`endif

    initial begin
        int  s;
        bit  found;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.num_k = '0;
        bus.num_q = '0;
        bus.sum_ready = 1'b0;
        bus.ofifo_valid = 1'b1;
        repeat (2) tick();
        chk("rst_inst", {2'd0, bus.inst}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_wr_sum", {31'd0, bus.wr_sum}, 32'd0);
        chk("rst_pop", {31'd0, bus.fifo_ext_rd}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Full pass, no stalls: done 21 cycles after start (macro off).
        do_start(4, 2, 0, s);
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        wait_idle("pass_k4_q2");

        // Start pulsed during QLOAD must be ignored.
        do_start(2, 3, 0, s);
        repeat (2) tick();
        bus.num_k = 6'd5;
        bus.num_q = 6'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle("start_in_qload");

        // num_q=0 behaves as one row.
        do_start(1, 0, 0, s);
        wait_idle("numq_zero");

        // Drain with ofifo_valid 1,0,1 around the drain window.
        bus.ofifo_valid = 1'b0;
        do_start(1, 2, 1, s);
        push_ev(iw(ORD, 0), 0, 0, 0, s + 15 + SX_OFF);
        push_ev(iw(ORD, 0), 0, 0, 0, s + 17 + SX_OFF);
        push_ev(30'd0, 0, 0, 1, s + 19 + SX_OFF);
        for (int i = 0; i < 60 && bus.busy === 1'b1; i++) begin
            bus.ofifo_valid = (cyc - s == 14 + SX_OFF) || (cyc - s == 16 + SX_OFF);
            tick();
        end
        bus.ofifo_valid = 1'b0;
        wait_idle("drain_toggle");
        bus.ofifo_valid = 1'b1;

`ifdef SEQ_NORM_EN
        // Peer sum held off for 5 cycles after the first wr_sum.
        sr_delay = 5;
        do_start(1, 2, 0, s);
        wait_idle("sumx_stall");
`endif

        // Asynchronous reset while executing row 3.
        do_start(1, 4, 2, s);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.inst === iw(QRD | EXE | PWR, 3)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_exec_addr3", {31'd0, found}, 32'd1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("abort_inst", {2'd0, bus.inst}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done", {31'd0, bus.done}, 32'd0);
        end
        chk("abort_pending", exp_q.size(), 32'd0);
        chk("abort_idle", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
